// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch
// and the memory stage. Data accesses win ties, but a fetch that has been passed
// over MAX_IF_WAIT times in a row is forced through. If the memory never acks,
// the access is aborted after TIMEOUT cycles and flagged with bus_err.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_IF_WAIT = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic              bus_err,
  output logic              pipe_stall
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam int IFW_W = (MAX_IF_WAIT > 0) ? $clog2(MAX_IF_WAIT + 1) : 1;
  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IFW_W-1:0] WAIT_LIMIT = IFW_W'(MAX_IF_WAIT);
  localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              owner_d_q, owner_d_d;
  logic [IFW_W-1:0]  if_wait_q, if_wait_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              m_req_q, m_req_d;
  logic              m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic              if_ready_q, if_ready_d;
  logic              d_ready_q, d_ready_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              bus_err_q, bus_err_d;
  logic              grant_d, grant_if;
  logic [DATA_W-1:0] resp_data;

  // Next-state logic: arbitration in IDLE, ack/timeout handling in BUSY,
  // and the single response cycle whose outputs are loaded on leaving BUSY.
  always_comb begin
    state_d    = state_q;
    owner_d_d  = owner_d_q;
    if_wait_d  = if_wait_q;
    to_cnt_d   = to_cnt_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    if_ready_d = 1'b0;
    d_ready_d  = 1'b0;
    if_rdata_d = '0;
    d_rdata_d  = '0;
    bus_err_d  = 1'b0;
    grant_d    = 1'b0;
    grant_if   = 1'b0;
    resp_data  = '0;

    case (state_q)
      IDLE: begin
        if (d_req && if_req) begin
          if (if_wait_q >= WAIT_LIMIT) begin
            grant_if = 1'b1;
          end else begin
            grant_d   = 1'b1;
            if_wait_d = if_wait_q + 1'b1;
          end
        end else if (d_req) begin
          grant_d = 1'b1;
        end else if (if_req) begin
          grant_if = 1'b1;
        end

        if (!if_req || grant_if) begin
          if_wait_d = '0;
        end

        if (grant_d) begin
          owner_d_d = 1'b1;
          m_addr_d  = d_addr;
          m_we_d    = d_we;
          m_wdata_d = d_wdata;
          m_req_d   = 1'b1;
          to_cnt_d  = '0;
          state_d   = BUSY;
        end else if (grant_if) begin
          owner_d_d = 1'b0;
          m_addr_d  = if_addr;
          m_we_d    = 1'b0;
          m_wdata_d = '0;
          m_req_d   = 1'b1;
          to_cnt_d  = '0;
          state_d   = BUSY;
        end
      end

      BUSY: begin
        if (m_ack || (to_cnt_q == TO_LAST)) begin
          if (m_ack && !m_we_q) begin
            resp_data = m_rdata;
          end
          m_req_d    = 1'b0;
          bus_err_d  = !m_ack;
          d_ready_d  = owner_d_q;
          if_ready_d = !owner_d_q;
          d_rdata_d  = owner_d_q ? resp_data : '0;
          if_rdata_d = owner_d_q ? '0 : resp_data;
          state_d    = RESP;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset discards any in-flight access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_d_q  <= 1'b0;
      if_wait_q  <= '0;
      to_cnt_q   <= '0;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_d_q  <= owner_d_d;
      if_wait_q  <= if_wait_d;
      to_cnt_q   <= to_cnt_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      if_ready_q <= if_ready_d;
      d_ready_q  <= d_ready_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // Output wiring; the stall is combinational on the requests.
  always_comb begin
    m_req      = m_req_q;
    m_we       = m_we_q;
    m_addr     = m_addr_q;
    m_wdata    = m_wdata_q;
    if_ready   = if_ready_q;
    d_ready    = d_ready_q;
    if_rdata   = if_rdata_q;
    d_rdata    = d_rdata_q;
    bus_err    = bus_err_q;
    pipe_stall = (if_req & ~if_ready_q) | (d_req & ~d_ready_q);
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter that shares one single-ported unified memory between the instruction-fetch stage and the memory stage of the 5-stage RISC-V pipeline. It latches one request at a time, drives a req/ack handshake toward the memory, and returns read data plus a one-cycle ready pulse to the winning stage. It also produces a pipeline stall signal. Data accesses have priority over fetches, and a starvation counter bounds how long a fetch can wait.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_IF_WAIT, 4, consecutive data grants tolerated while a fetch is pending before the fetch is forced to win
- TIMEOUT, 64, cycles in BUSY without m_ack before the access is aborted

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request; held until if_ready
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetch data, valid while if_ready=1
- if_ready  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request; held until d_ready
- d_we  in  1  1=store, 0=load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, valid while d_ready=1
- d_ready  out  1  one-cycle completion pulse for data
- m_req  out  1  memory request, registered
- m_we  out  1  memory write enable, registered
- m_addr  out  ADDR_W  memory address, registered
- m_wdata  out  DATA_W  memory write data, registered
- m_rdata  in  DATA_W  memory read data, valid with m_ack
- m_ack  in  1  memory completion, sampled only in BUSY
- bus_err  out  1  one-cycle pulse, coincident with ready, on timeout
- pipe_stall  out  1  combinational: (if_req & ~if_ready) | (d_req & ~d_ready)

## Operation
- States: IDLE, BUSY, RESP. Registers: owner (IF/D), if_wait counter (0..MAX_IF_WAIT), timeout counter.
- IDLE arbitration, evaluated at each edge:
  - Only d_req: grant D.
  - Only if_req: grant IF.
  - Both, with if_wait < MAX_IF_WAIT: grant D and increment if_wait.
  - Both, with if_wait == MAX_IF_WAIT: grant IF.
  - Any IF grant clears if_wait. if_wait also clears whenever IDLE sees if_req=0.
- On grant, in the same edge:
  - Latch owner.
  - Load m_addr and m_we from the winner; load m_wdata from d_wdata (D) or 0 (IF).
  - Set m_req=1, clear the timeout counter, and go to BUSY.
- BUSY:
  - m_req, m_addr, m_we, m_wdata held constant.
  - On m_ack: capture m_rdata, or 0 for stores. Drop m_req and go to RESP.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT-1 without m_ack: drop m_req, set the captured data to 0, flag an error, and go to RESP.
- RESP:
  - Exactly one cycle. The owner's ready=1 and its rdata = captured data. bus_err=1 if the access timed out.
  - Requests are ignored in this state. Next state is IDLE.
- Requester rules:
  - A requester holds req, address and data stable from assertion through its ready cycle.
  - A requester may reassert req the cycle after ready; it is sampled in IDLE.
- Outside RESP: if_rdata and d_rdata read 0, and both ready outputs are 0.
- m_ack in IDLE or RESP is ignored.
- Reset mid-operation:
  - Next edge forces IDLE, owner=IF, all counters 0, and all registered outputs 0.
  - The in-flight access is discarded; no ready pulse is issued for it.
  - A late m_ack after reset is ignored.

## Timing
- Reset values: m_req=0, m_we=0, m_addr=0, m_wdata=0, if_ready=0, d_ready=0, if_rdata=0, d_rdata=0, bus_err=0.
- pipe_stall follows its inputs combinationally.
- Request sampled at edge N (IDLE) → m_req high from cycle N+1.
- m_ack sampled high at edge K (BUSY) → ready and rdata valid in cycle K+1 → IDLE in cycle K+2.
- Minimum latency, with the memory acking in the first m_req cycle: req at cycle 0, ready in cycle 2. A new grant is possible at edge 3.
- Back-to-back throughput: at most one access per 3 cycles.
- Timeout: m_req held for exactly TIMEOUT cycles, then the RESP cycle.

## Test plan
- Single load, memory acks 1 cycle after m_req. Drive d_req, d_we=0, d_addr=0x100; m_rdata=0xDEADBEEF. Required: m_req high cycles 1–2, m_addr=0x100, d_ready=1 with d_rdata=0xDEADBEEF in cycle 3, pipe_stall=1 cycles 0–2.
- Store. d_we=1, d_addr=0x40, d_wdata=0x12345678, ack in the first m_req cycle. Required: m_we=1, m_wdata=0x12345678, d_ready in cycle 2, d_rdata=0.
- Contention and starvation, MAX_IF_WAIT=4. Hold if_req (if_addr=0x0) and reassert d_req after each d_ready. Required: four D grants, then an IF grant on the fifth arbitration, then if_wait returns to 0.
- Timeout, TIMEOUT=8. Fetch with m_ack tied 0. Required: m_req high exactly 8 cycles, then if_ready=1, bus_err=1, if_rdata=0 in the same cycle; next state IDLE.
- Reset mid-BUSY. Assert reset for one edge while m_req=1, then pulse m_ack. Required: all outputs 0 the cycle after reset, no ready pulse, state IDLE; a subsequent if_req completes normally.
- Simultaneous first requests with if_wait=0. Required: D granted first; IF granted at the next IDLE; if_ready asserted once, with the correct data.
